// File: rtl/local_eject_serializer.sv
// local_eject_serializer: buffers eight ejection lanes in per-lane FIFOs and serializes them round-robin onto one ready/valid port
// Ports:
//   clk, rst (async, active low)
//   in_local..in_zneg     lanes 0-6, non-reduction packets; bit DataWidth-1 = valid
//   in_reduction          lane 7, completed reduction packet
//   out_ready             sink accepts out_data this cycle
//   out_data              serialized packet; bit DataWidth-1 = valid
//   stall                 registered: some lane occupancy >= LaneDepth-StallMargin
//   eject_count           packets accepted by the sink (wrapping)
//   drop_count            packets dropped on full lanes (saturating)
//   overflow              sticky drop flag
module local_eject_serializer #(
    parameter int DataWidth   = 256,
    parameter int LaneDepth   = 4,
    parameter int StallMargin = 1,
    parameter int CntWidth    = 32,
    parameter int DropWidth   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] in_local,
    input  logic [DataWidth-1:0] in_yneg,
    input  logic [DataWidth-1:0] in_ypos,
    input  logic [DataWidth-1:0] in_xpos,
    input  logic [DataWidth-1:0] in_xneg,
    input  logic [DataWidth-1:0] in_zpos,
    input  logic [DataWidth-1:0] in_zneg,
    input  logic [DataWidth-1:0] in_reduction,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic                 stall,
    output logic [CntWidth-1:0]  eject_count,
    output logic [DropWidth-1:0] drop_count,
    output logic                 overflow
);
    localparam int AW = $clog2(LaneDepth);
    localparam int VB = DataWidth - 1;
    localparam int STALL_INT = LaneDepth - StallMargin;
    localparam logic [AW:0] FULL_CNT = LaneDepth[AW:0];
    localparam logic [AW:0] STALL_CNT = STALL_INT[AW:0];

    logic [DataWidth-1:0] lane_in [8];
    logic [DataWidth-1:0] mem_q [8][LaneDepth];
    logic [DataWidth-1:0] mem_d [8][LaneDepth];
    logic [AW-1:0]        wptr_q [8], wptr_d [8], rptr_q [8], rptr_d [8];
    logic [AW:0]          cnt_q [8], cnt_d [8];
    logic [2:0]           last_grant_q, last_grant_d, grant, idx;
    logic [DataWidth-1:0] out_q, out_d;
    logic [CntWidth-1:0]  eject_q, eject_d;
    logic [DropWidth-1:0] drop_q, drop_d;
    logic [DropWidth:0]   drop_sum;
    logic                 stall_q, stall_d, overflow_q, overflow_d;
    logic                 found, load, pop;
    logic [7:0]           pop_lane, push, drop;
    logic [3:0]           ndrop;

    assign lane_in[0] = in_local;
    assign lane_in[1] = in_yneg;
    assign lane_in[2] = in_ypos;
    assign lane_in[3] = in_xpos;
    assign lane_in[4] = in_xneg;
    assign lane_in[5] = in_zpos;
    assign lane_in[6] = in_zneg;
    assign lane_in[7] = in_reduction;

    always_comb begin
        load  = !out_q[VB] || out_ready;
        found = 1'b0;
        grant = last_grant_q;
        idx   = '0;
        // Search starts one past the last granted lane; only buffered entries compete.
        for (int k = 0; k < 8; k++) begin
            idx = last_grant_q + 3'(k + 1);
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                grant = idx;
            end
        end
        pop          = load && found;
        last_grant_d = pop ? grant : last_grant_q;
        out_d        = load ? (found ? mem_q[grant][rptr_q[grant]] : '0) : out_q;
        eject_d      = eject_q + CntWidth'(out_q[VB] & out_ready);
        mem_d        = mem_q;
        pop_lane     = '0;
        push         = '0;
        drop         = '0;
        ndrop        = '0;
        stall_d      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pop_lane[i] = pop && grant == 3'(i);
            // A full lane still accepts when it is popped in the same cycle.
            push[i]     = lane_in[i][VB] && (cnt_q[i] != FULL_CNT || pop_lane[i]);
            drop[i]     = lane_in[i][VB] && !push[i];
            if (push[i]) mem_d[i][wptr_q[i]] = lane_in[i];
            wptr_d[i]   = wptr_q[i] + AW'(push[i]);
            rptr_d[i]   = rptr_q[i] + AW'(pop_lane[i]);
            cnt_d[i]    = cnt_q[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop_lane[i]};
            ndrop       = ndrop + 4'(drop[i]);
            stall_d     = stall_d || cnt_d[i] >= STALL_CNT;
        end
        drop_sum   = {1'b0, drop_q} + {{(DropWidth - 3){1'b0}}, ndrop};
        drop_d     = drop_sum[DropWidth] ? '1 : drop_sum[DropWidth-1:0];
        overflow_d = overflow_q || (|drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            last_grant_q <= 3'd7;
            out_q        <= '0;
            eject_q      <= '0;
            drop_q       <= '0;
            stall_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            out_q        <= out_d;
            eject_q      <= eject_d;
            drop_q       <= drop_d;
            stall_q      <= stall_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage carries no reset: pointers and occupancies define what is live.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign out_data    = out_q;
    assign stall       = stall_q;
    assign eject_count = eject_q;
    assign drop_count  = drop_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_local_eject_serializer.sv
// tb_local_eject_serializer: randomized bench for local_eject_serializer against a queue-based reference model
module tb_local_eject_serializer;
    localparam int DW = 256;
    localparam int LD = 4;
    localparam int SM = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] lane_v [8];
    logic [DW-1:0] out_data;
    logic          stall, overflow;
    logic [31:0]   eject_count;
    logic [15:0]   drop_count;

    logic [DW-1:0] mq [8][$];
    logic [DW-1:0] m_out;
    int            m_lg;
    logic [31:0]   m_eject;
    int            m_drop;
    bit            m_ovf, m_stall;
    logic [DW-1:0] acc [$];
    int            checks = 0;
    int            errors = 0;

    local_eject_serializer dut (
        .clk(clk), .rst(rst),
        .in_local(lane_v[0]), .in_yneg(lane_v[1]), .in_ypos(lane_v[2]), .in_xpos(lane_v[3]),
        .in_xneg(lane_v[4]), .in_zpos(lane_v[5]), .in_zneg(lane_v[6]), .in_reduction(lane_v[7]),
        .out_ready(out_ready), .out_data(out_data), .stall(stall),
        .eject_count(eject_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pkt(bit v);
        logic [DW-1:0] p;
        for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = $urandom();
        p[DW-1] = v;
        return p;
    endfunction

    task automatic clear_lanes();
        for (int i = 0; i < 8; i++) lane_v[i] = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mq[i].delete();
        m_out = '0; m_lg = 7; m_eject = '0; m_drop = 0; m_ovf = 0; m_stall = 0;
    endtask

    // Applies the current inputs for one clock edge; the model advances by the behavioural rules.
    task automatic step();
        int g, drops;
        if (out_data[DW-1] && out_ready) acc.push_back(out_data);
        if (m_out[DW-1] && out_ready) m_eject++;
        if (!m_out[DW-1] || out_ready) begin
            g = -1;
            for (int k = 0; k < 8; k++)
                if (g < 0 && mq[(m_lg + 1 + k) % 8].size() > 0) g = (m_lg + 1 + k) % 8;
            if (g >= 0) begin
                m_out = mq[g].pop_front();
                m_lg = g;
            end else m_out = '0;
        end
        drops = 0;
        for (int i = 0; i < 8; i++)
            if (lane_v[i][DW-1]) begin
                if (mq[i].size() < LD) mq[i].push_back(lane_v[i]);
                else drops++;
            end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        if (drops > 0) m_ovf = 1;
        m_stall = 0;
        for (int i = 0; i < 8; i++) if (mq[i].size() >= LD - SM) m_stall = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_lanes();
        out_ready = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_lanes();
        #2;
        checks += 5;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out got %h want 0", out_data); end
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        if (eject_count !== '0) begin errors++; $display("FAIL reset_eject got %0d want 0", eject_count); end
        if (drop_count !== '0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] p0;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) lane_v[i] = pkt(1);
            step();
        end
        clear_lanes();
        step();
        rst = 1'b0;
        #1;
        model_reset();
        checks += 4;
        if (out_data !== '0) begin errors++; $display("FAIL midrst_out got %h want 0", out_data); end
        if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", stall); end
        if (eject_count !== '0) begin errors++; $display("FAIL midrst_eject got %0d want 0", eject_count); end
        if (drop_count !== '0) begin errors++; $display("FAIL midrst_drop got %0d want 0", drop_count); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        p0 = pkt(1);
        lane_v[0] = p0;
        lane_v[3] = pkt(1);
        step();
        clear_lanes();
        step();
        checks++;
        if (out_data !== p0) begin errors++; $display("FAIL midrst_first got %h want %h", out_data, p0); end
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL midrst_drained got %h want 0", out_data); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] sent [8];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sent[i] = pkt(1);
            sent[i][7:0] = 8'(i);
            lane_v[i] = sent[i];
        end
        step();
        clear_lanes();
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (out_data !== sent[c]) begin errors++; $display("FAIL rr_lane%0d got %h want %h", c, out_data, sent[c]); end
        end
        step();
        checks += 2;
        if (out_data !== '0) begin errors++; $display("FAIL rr_idle got %h want 0", out_data); end
        if (eject_count !== 32'd8) begin errors++; $display("FAIL rr_eject got %0d want 8", eject_count); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] p;
        do_reset();
        p = '0;
        p[DW-1] = 1'b1;
        p[7:0] = 8'hA5;
        lane_v[7] = p;
        step();
        clear_lanes();
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (out_data !== p) begin errors++; $display("FAIL bp_hold%0d got %h want %h", c, out_data, p); end
        end
        out_ready = 1'b1;
        step();
        checks += 2;
        if (out_data !== '0) begin errors++; $display("FAIL bp_after got %h want 0", out_data); end
        if (eject_count !== 32'd1) begin errors++; $display("FAIL bp_eject got %0d want 1", eject_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < LD + 3; c++) begin
            lane_v[3] = pkt(1);
            step();
            checks++;
            if (stall !== (c >= 3)) begin errors++; $display("FAIL ovf_stall%0d got %b want %b", c, stall, c >= 3); end
        end
        clear_lanes();
        checks += 2;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (out_data !== m_out) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", c, out_data, m_out); end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] sent [$];
        do_reset();
        acc.delete();
        for (int c = 0; c < LD + 1; c++) begin
            sent.push_back(pkt(1));
            lane_v[4] = sent[$];
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sent.push_back(pkt(1));
            lane_v[4] = sent[$];
            step();
            checks++;
            if (drop_count !== '0) begin errors++; $display("FAIL fullpop_drop%0d got %0d want 0", c, drop_count); end
        end
        clear_lanes();
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (acc.size() != sent.size()) begin errors++; $display("FAIL fullpop_count got %0d want %0d", acc.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < acc.size(); i++) begin
            checks++;
            if (acc[i] !== sent[i]) begin errors++; $display("FAIL fullpop_order%0d got %h want %h", i, acc[i], sent[i]); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_invalid();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 8; i++) lane_v[i] = pkt(0);
            out_ready = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (out_data !== '0) begin errors++; $display("FAIL inv_out%0d got %h want 0", c, out_data); end
        end
        clear_lanes();
        checks += 3;
        if (eject_count !== '0) begin errors++; $display("FAIL inv_eject got %0d want 0", eject_count); end
        if (drop_count !== '0) begin errors++; $display("FAIL inv_drop got %0d want 0", drop_count); end
        if (stall !== 1'b0) begin errors++; $display("FAIL inv_stall got %b want 0", stall); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) lane_v[i] = pkt($urandom_range(0, 2) == 0);
            out_ready = $urandom_range(0, 9) < 7;
            step();
            checks += 5;
            if (out_data !== m_out) begin errors++; $display("FAIL rnd_out%0d got %h want %h", c, out_data, m_out); end
            if (stall !== m_stall) begin errors++; $display("FAIL rnd_stall%0d got %b want %b", c, stall, m_stall); end
            if (eject_count !== m_eject) begin errors++; $display("FAIL rnd_eject%0d got %0d want %0d", c, eject_count, m_eject); end
            if (drop_count !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop%0d got %0d want %0d", c, drop_count, m_drop); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf%0d got %b want %b", c, overflow, m_ovf); end
        end
        clear_lanes();
    endtask

    task automatic test_drop_saturation();
        do_reset();
        for (int c = 0; c < 8200; c++) begin
            for (int i = 0; i < 8; i++) lane_v[i] = pkt(1);
            step();
            if (c == 10 || c == 8000) begin
                checks++;
                if (drop_count !== 16'(m_drop)) begin errors++; $display("FAIL sat_mid%0d got %0d want %0d", c, drop_count, m_drop); end
            end
        end
        clear_lanes();
        checks += 3;
        if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_drop got %h want ffff", drop_count); end
        if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b want 1", stall); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", overflow); end
    endtask

    initial begin
        clear_lanes();
        model_reset();
        test_reset();
        test_reset_mid_burst();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_invalid();
        test_random();
        test_drop_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/local_eject_serializer.md
# local_eject_serializer

Sits directly downstream of the local-port crossbar mux. Accepts up to eight ejected packets per cycle: seven non-reduction lanes plus one completed-reduction lane. Buffers each lane in a small FIFO and serializes them round-robin onto the single node ejection port under ready/valid backpressure. Also raises an upstream stall, and counts ejected and dropped packets.

## Interface
- DataWidth, 256, packet width; bit DataWidth-1 is the valid bit
- LaneDepth, 4, entries per lane FIFO (power of two, ≥2)
- StallMargin, 1, stall asserts when any lane occupancy ≥ LaneDepth-StallMargin
- CntWidth, 32, width of ejected-packet counter
- DropWidth, 16, width of per-block drop counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_local, in_yneg, in_ypos, in_xpos, in_xneg, in_zpos, in_zneg  in  DataWidth each  lanes 0-6, non-reduction ejected packets
- in_reduction  in  DataWidth  lane 7, completed reduction packet
- out_ready  in  1  ejection port can accept a packet this cycle
- out_data  out  DataWidth  serialized packet; out_data[DataWidth-1] is out valid
- stall  out  1  registered upstream stall request
- eject_count  out  CntWidth  packets accepted by the sink, wraps
- drop_count  out  DropWidth  packets dropped on full lanes, saturating
- overflow  out  1  sticky; set on first drop

## Operation
- Lane write: a lane input with bit DataWidth-1 = 1 is pushed into its FIFO at the clock edge. Inputs with that bit = 0 are ignored.
- Full lane:
  - If the lane is full and is not popped in the same cycle, the packet is dropped.
  - A drop increments drop_count (saturating at all-ones) and sets overflow.
  - If several lanes drop in one cycle, drop_count adds the number of drops, saturating.
- Push and pop on the same lane in the same cycle are always accepted, including when the lane is full. Occupancy is unchanged.
- Output register:
  - out_data loads when out_data[DataWidth-1] = 0 or out_ready = 1.
  - When a load occurs and any lane is non-empty, the granted lane's head is popped and loaded.
  - When a load occurs and all lanes are empty, zero is loaded.
  - When out_data is valid and out_ready = 0, out_data holds unchanged and no lane is popped.
- Arbitration:
  - Round-robin over lanes 0-7 with pointer last_grant, reset value 7.
  - The search starts at (last_grant+1) mod 8. The first non-empty lane is granted.
  - last_grant updates only on a pop.
  - Only FIFO contents are arbitrated; packets arriving this cycle are not eligible. There is no bypass.
- eject_count increments (wrapping) each cycle in which out_data is valid and out_ready = 1.
- stall is a register, computed from post-edge occupancies: stall = 1 iff any lane occupancy ≥ LaneDepth-StallMargin.
- Packet contents pass through unmodified. Per-lane order is FIFO order.

## Timing
- Reset (rst low, asynchronous): all outputs, FIFO pointers and occupancies are 0; last_grant = 7. Asserting reset mid-operation discards all buffered packets immediately.
- Release: the first edge with rst high is a normal operating edge.
- Latency: a packet sampled at edge N into an empty block with out_ready = 1 appears on out_data after edge N+1.
- Throughput: 1 packet/cycle when out_ready is held high. A fully loaded block drains 8·LaneDepth packets in 8·LaneDepth cycles.
- stall: reflects occupancy one edge later. With StallMargin = 1 it asserts after the edge at which a lane reaches LaneDepth-1 entries.
- Handshake: the sink must sample out_data only when both valid and out_ready are high. Valid, once asserted, stays asserted with stable data until accepted.
- Simultaneous events:
  - Pop and push on the same full lane: accepted.
  - Drops on all 8 lanes in one cycle: drop_count += 8, saturating.
  - Counter wrap: eject_count wraps from all-ones to 0. drop_count holds at all-ones.

## Test plan
- Reset mid-burst: fill lanes 0-2 with 2 packets each, assert rst low for 1 cycle -> out_data = 0, stall = 0, counters = 0. The first packet afterwards is granted from lane 0.
- Round-robin fairness: one valid packet on all 8 lanes in one cycle, out_ready = 1 -> out_data emits lanes 0,1,...,7 on 8 consecutive cycles. eject_count = 8.
- Backpressure hold: packet 0xA5 (with valid bit) on lane 7, out_ready = 0 for 5 cycles -> out_data stays stable on that packet. Raise out_ready -> accepted once; next cycle out_data = 0; eject_count = 1.
- Overflow: out_ready = 0, drive lane 3 valid for LaneDepth+3 cycles (one packet occupies out_data) -> drop_count = 2, overflow = 1. stall = 1 from the cycle after occupancy reaches 3.
- Full lane with simultaneous pop: lane 4 full, out_ready = 1, new packet each cycle for 10 cycles -> drop_count = 0. Output order equals input order.
- Invalid inputs ignored: all lanes driven with bit 255 = 0 and random payload for 20 cycles -> out_data = 0 throughout, counters unchanged.
